regmodel0_ocp2_reg_bridge: RTL and testbench

REGMODEL0_OCP2_REG_BRIDGE -- requirements
Module: regmodel0_ocp2_reg_bridge

---
 rtl/regmodel0_ocp2_reg_bridge_if.sv | 26 ++
 rtl/regmodel0_ocp2_reg_bridge.sv | 159 +++++++++++++++
 tb/tb_regmodel0_ocp2_reg_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regmodel0_ocp2_reg_bridge_if.sv
// OCP2 slave-side signal bundle for the register bridge.
// The master drives commands; the slave returns accept and response.
interface regmodel0_ocp2_reg_bridge_if #(
    parameter int ADDR_W = 15
) ();
    logic              mreset_n;
    logic [2:0]        mcmd;
    logic [ADDR_W-1:0] maddr;
    logic [3:0]        mbyteen;
    logic [5:0]        mreqinfo;
    logic [31:0]       mdata;
    logic              mrespaccept;
    logic              scmdaccept;
    logic [1:0]        sresp;
    logic [31:0]       sdata;

    modport master (
        output mreset_n, mcmd, maddr, mbyteen, mreqinfo, mdata, mrespaccept,
        input  scmdaccept, sresp, sdata
    );

    modport slave (
        input  mreset_n, mcmd, maddr, mbyteen, mreqinfo, mdata, mrespaccept,
        output scmdaccept, sresp, sdata
    );
endinterface

// File: rtl/regmodel0_ocp2_reg_bridge.sv
// OCP2 single-transaction slave bridging to a simple req/ack register port.
// Every command gets exactly one response; illegal commands never touch the registers.
module regmodel0_ocp2_reg_bridge #(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    regmodel0_ocp2_reg_bridge_if.slave ocp,
    output logic                      reg_req,
    output logic                      reg_wr,
    output logic [ADDR_W-3:0]         reg_addr,
    output logic [3:0]                reg_be,
    output logic [31:0]               reg_wdata,
    output logic [5:0]                reg_info,
    input  logic                      reg_ack,
    input  logic [31:0]               reg_rdata,
    input  logic                      reg_err
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACCESS = 2'd1;
    localparam logic [1:0]  ST_RESP   = 2'd2;

    localparam logic [2:0]  CMD_IDLE  = 3'd0;
    localparam logic [2:0]  CMD_WR    = 3'd1;
    localparam logic [2:0]  CMD_RD    = 3'd2;

    localparam logic [1:0]  RESP_NULL = 2'b00;
    localparam logic [1:0]  RESP_DVA  = 2'b01;
    localparam logic [1:0]  RESP_ERR  = 2'b11;

    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        sresp_q, sresp_d;
    logic [31:0]       sdata_q, sdata_d;
    logic              reg_req_q, reg_req_d;
    logic              reg_wr_q, reg_wr_d;
    logic [ADDR_W-3:0] reg_addr_q, reg_addr_d;
    logic [3:0]        reg_be_q, reg_be_d;
    logic [31:0]       reg_wdata_q, reg_wdata_d;
    logic [5:0]        reg_info_q, reg_info_d;

    logic soft_rst;
    logic accept;
    logic is_wr;
    logic is_rd;

    // Either reset source wins over any same-cycle command, so acceptance is masked too.
    assign soft_rst = reset | ~ocp.mreset_n;
    assign accept   = (state_q == ST_IDLE) && (ocp.mcmd != CMD_IDLE) && !soft_rst;
    assign is_wr    = (ocp.mcmd == CMD_WR);
    assign is_rd    = (ocp.mcmd == CMD_RD);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sresp_d     = sresp_q;
        sdata_d     = sdata_q;
        reg_req_d   = reg_req_q;
        reg_wr_d    = reg_wr_q;
        reg_addr_d  = reg_addr_q;
        reg_be_d    = reg_be_q;
        reg_wdata_d = reg_wdata_q;
        reg_info_d  = reg_info_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!(is_wr || is_rd) || (ocp.maddr[1:0] != 2'b00)) begin
                        state_d = ST_RESP;
                        sresp_d = RESP_ERR;
                        sdata_d = '0;
                    end else if (is_wr && (ocp.mbyteen == 4'h0)) begin
                        state_d = ST_RESP;
                        sresp_d = RESP_DVA;
                        sdata_d = '0;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = '0;
                        reg_req_d   = 1'b1;
                        reg_wr_d    = is_wr;
                        reg_addr_d  = ocp.maddr[ADDR_W-1:2];
                        reg_be_d    = is_wr ? ocp.mbyteen : 4'hF;
                        reg_wdata_d = ocp.mdata;
                        reg_info_d  = ocp.mreqinfo;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack on the final counted cycle still completes normally.
                if (reg_ack) begin
                    state_d   = ST_RESP;
                    cnt_d     = '0;
                    reg_req_d = 1'b0;
                    sresp_d   = reg_err ? RESP_ERR : RESP_DVA;
                    sdata_d   = (!reg_err && !reg_wr_q) ? reg_rdata : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    cnt_d     = '0;
                    reg_req_d = 1'b0;
                    sresp_d   = RESP_ERR;
                    sdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (ocp.mrespaccept) begin
                    state_d = ST_IDLE;
                    sresp_d = RESP_NULL;
                    sdata_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sresp_q     <= RESP_NULL;
            sdata_q     <= '0;
            reg_req_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_be_q    <= '0;
            reg_wdata_q <= '0;
            reg_info_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sresp_q     <= sresp_d;
            sdata_q     <= sdata_d;
            reg_req_q   <= reg_req_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_be_q    <= reg_be_d;
            reg_wdata_q <= reg_wdata_d;
            reg_info_q  <= reg_info_d;
        end
    end

    assign ocp.scmdaccept = accept;
    assign ocp.sresp      = sresp_q;
    assign ocp.sdata      = sdata_q;
    assign reg_req        = reg_req_q;
    assign reg_wr         = reg_wr_q;
    assign reg_addr       = reg_addr_q;
    assign reg_be         = reg_be_q;
    assign reg_wdata      = reg_wdata_q;
    assign reg_info       = reg_info_q;

endmodule

// File: tb/tb_regmodel0_ocp2_reg_bridge.sv
// Self-checking bench for the OCP2 register bridge: vector table plus corner sequences.
module tb_regmodel0_ocp2_reg_bridge;

    localparam int ADDR_W  = 15;
    localparam int TIMEOUT = 4;

    localparam logic [1:0] R_NULL = 2'b00;
    localparam logic [1:0] R_DVA  = 2'b01;
    localparam logic [1:0] R_ERR  = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              reg_req, reg_wr;
    logic [ADDR_W-3:0] reg_addr;
    logic [3:0]        reg_be;
    logic [31:0]       reg_wdata;
    logic [5:0]        reg_info;
    logic              reg_ack = 1'b0;
    logic [31:0]       reg_rdata = '0;
    logic              reg_err = 1'b0;

    regmodel0_ocp2_reg_bridge_if #(.ADDR_W(ADDR_W)) ocp ();

    regmodel0_ocp2_reg_bridge #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ocp       (ocp.slave),
        .reg_req   (reg_req),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_be    (reg_be),
        .reg_wdata (reg_wdata),
        .reg_info  (reg_info),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .reg_err   (reg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mcmd;
        logic [14:0] maddr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [5:0]  info;
        int          ack_idx;
        logic [31:0] rdata;
        logic        err;
        int          exp_req;
        int          exp_lat;
        logic [12:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_wr;
        logic [1:0]  exp_sresp;
        logic [31:0] exp_sdata;
    } vec_t;

    typedef struct {
        logic [1:0]  sresp;
        logic [31:0] sdata;
    } resp_t;

    int    checks = 0;
    int    failures = 0;
    resp_t sb[$];
    vec_t  vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        resp_t e;
        ocp.mcmd     = v.mcmd;
        ocp.maddr    = v.maddr;
        ocp.mbyteen  = v.be;
        ocp.mdata    = v.data;
        ocp.mreqinfo = v.info;
        @(negedge clk);
        chk("scmdaccept_N", {31'd0, ocp.scmdaccept}, 32'd1);
        e.sresp = v.exp_sresp;
        e.sdata = v.exp_sdata;
        sb.push_back(e);
    endtask

    task automatic complete(input vec_t v);
        int    req_cycles;
        bit    got;
        resp_t e;
        req_cycles = 0;
        got = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(posedge clk); #1;
            ocp.mcmd        = 3'd0;
            ocp.mrespaccept = 1'b1;
            if (reg_req && (c - 1) == v.ack_idx) begin
                reg_ack   = 1'b1;
                reg_rdata = v.rdata;
                reg_err   = v.err;
            end else begin
                reg_ack   = 1'b0;
                reg_rdata = $urandom;
                reg_err   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (reg_req) begin
                req_cycles++;
                chk("reg_addr", {19'd0, reg_addr}, {19'd0, v.exp_addr});
                chk("reg_be", {28'd0, reg_be}, {28'd0, v.exp_be});
                chk("reg_wr", {31'd0, reg_wr}, {31'd0, v.exp_wr});
                chk("reg_wdata", reg_wdata, v.data);
                chk("reg_info", {26'd0, reg_info}, {26'd0, v.info});
            end
            if (ocp.sresp != R_NULL) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got sresp %b with empty scoreboard", ocp.sresp);
                end else begin
                    e = sb.pop_front();
                    chk("sresp", {30'd0, ocp.sresp}, {30'd0, e.sresp});
                    chk("sdata", ocp.sdata, e.sdata);
                    chk("resp_latency", c, v.exp_lat);
                end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: got no response, expected sresp %b", v.exp_sresp);
            sb.delete();
        end
        chk("req_cycles", req_cycles, v.exp_req);
        reg_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v);
        complete(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected TB_RESULT");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //         cmd    maddr      be    data          info   ack rdata         err req lat addr      be    wr    sresp  sdata
        vecs[0]  = '{3'd2, 15'h0010, 4'h0, 32'h00000000, 6'h01, 2,  32'hDEADBEEF, 1'b0, 3, 4, 13'h004, 4'hF, 1'b0, R_DVA, 32'hDEADBEEF};
        vecs[1]  = '{3'd1, 15'h0100, 4'h3, 32'h12345678, 6'h2A, 0,  32'h55555555, 1'b1, 1, 2, 13'h040, 4'h3, 1'b1, R_ERR, 32'h0};
        vecs[2]  = '{3'd5, 15'h0040, 4'hF, 32'h00000000, 6'h00, 0,  32'h0,        1'b0, 0, 1, 13'h000, 4'h0, 1'b0, R_ERR, 32'h0};
        vecs[3]  = '{3'd2, 15'h0002, 4'hF, 32'h00000000, 6'h00, 0,  32'h0,        1'b0, 0, 1, 13'h000, 4'h0, 1'b0, R_ERR, 32'h0};
        vecs[4]  = '{3'd1, 15'h0008, 4'h0, 32'hFFFFFFFF, 6'h00, 0,  32'h0,        1'b0, 0, 1, 13'h000, 4'h0, 1'b0, R_DVA, 32'h0};
        vecs[5]  = '{3'd2, 15'h0ABC, 4'hF, 32'h00000000, 6'h3F, 99, 32'h0,        1'b0, 4, 5, 13'h2AF, 4'hF, 1'b0, R_ERR, 32'h0};
        vecs[6]  = '{3'd1, 15'h7FFC, 4'hF, 32'hA5A5A5A5, 6'h15, 1,  32'h0,        1'b0, 2, 3, 13'h1FFF, 4'hF, 1'b1, R_DVA, 32'h0};
        vecs[7]  = '{3'd2, 15'h1234, 4'h1, 32'h00000000, 6'h07, 3,  32'h0BADF00D, 1'b0, 4, 5, 13'h48D, 4'hF, 1'b0, R_DVA, 32'h0BADF00D};
        vecs[8]  = '{3'd3, 15'h0000, 4'hF, 32'h00000000, 6'h00, 0,  32'h0,        1'b0, 0, 1, 13'h000, 4'h0, 1'b0, R_ERR, 32'h0};
        vecs[9]  = '{3'd7, 15'h0000, 4'hF, 32'h00000000, 6'h00, 0,  32'h0,        1'b0, 0, 1, 13'h000, 4'h0, 1'b0, R_ERR, 32'h0};
        vecs[10] = '{3'd2, 15'h0004, 4'hF, 32'h00000000, 6'h00, 0,  32'hFFFFFFFF, 1'b1, 1, 2, 13'h001, 4'hF, 1'b0, R_ERR, 32'h0};
        vecs[11] = '{3'd1, 15'h0101, 4'hF, 32'h00000000, 6'h00, 0,  32'h0,        1'b0, 0, 1, 13'h000, 4'h0, 1'b0, R_ERR, 32'h0};
        vecs[12] = '{3'd1, 15'h0200, 4'hC, 32'hCAFEBABE, 6'h00, 2,  32'hFFFFFFFF, 1'b0, 3, 4, 13'h080, 4'hC, 1'b1, R_DVA, 32'h0};

        ocp.mreset_n    = 1'b1;
        ocp.mcmd        = 3'd0;
        ocp.maddr       = '0;
        ocp.mbyteen     = '0;
        ocp.mreqinfo    = '0;
        ocp.mdata       = '0;
        ocp.mrespaccept = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scmdaccept", {31'd0, ocp.scmdaccept}, 32'd0);
        chk("rst_sresp", {30'd0, ocp.sresp}, 32'd0);
        chk("rst_sdata", ocp.sdata, 32'd0);
        chk("rst_reg_req", {31'd0, reg_req}, 32'd0);
        chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
        chk("rst_reg_addr", {19'd0, reg_addr}, 32'd0);
        chk("rst_reg_be", {28'd0, reg_be}, 32'd0);
        chk("rst_reg_wdata", reg_wdata, 32'd0);
        chk("rst_reg_info", {26'd0, reg_info}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset beats a simultaneous command
        @(posedge clk); #1;
        reset = 1'b1;
        ocp.mcmd = 3'd2;
        ocp.maddr = 15'h0010;
        @(negedge clk);
        chk("rstcmd_scmdaccept", {31'd0, ocp.scmdaccept}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ocp.mcmd = 3'd0;
        @(negedge clk);
        chk("rstcmd_reg_req", {31'd0, reg_req}, 32'd0);
        chk("rstcmd_sresp", {30'd0, ocp.sresp}, 32'd0);
        @(posedge clk); #1;

        // Table of single transactions
        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Late ack after timeout is ignored
        run_vec(vecs[5]);
        reg_ack = 1'b1;
        reg_rdata = 32'h13579BDF;
        @(negedge clk);
        chk("late_ack_req", {31'd0, reg_req}, 32'd0);
        chk("late_ack_sresp", {30'd0, ocp.sresp}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            reg_ack = 1'b0;
            @(negedge clk);
            chk("late_ack_no_resp", {30'd0, ocp.sresp}, 32'd0);
        end
        @(posedge clk); #1;

        // Response backpressure with a pending command
        v = '{3'd2, 15'h0020, 4'hF, 32'h0, 6'h11, 0, 32'hCAFEF00D, 1'b0, 1, 2, 13'h008, 4'hF, 1'b0, R_DVA, 32'hCAFEF00D};
        ocp.mrespaccept = 1'b0;
        issue(v);
        @(posedge clk); #1;
        reg_ack = 1'b1;
        reg_rdata = 32'hCAFEF00D;
        reg_err = 1'b0;
        @(negedge clk);
        chk("bp_reg_req", {31'd0, reg_req}, 32'd1);
        chk("bp_access_scmdaccept", {31'd0, ocp.scmdaccept}, 32'd0);
        @(posedge clk); #1;
        reg_ack = 1'b0;
        @(negedge clk);
        void'(sb.pop_front());
        chk("bp_sresp", {30'd0, ocp.sresp}, {30'd0, R_DVA});
        chk("bp_sdata", ocp.sdata, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            reg_ack = 1'($urandom_range(0, 1));
            reg_rdata = $urandom;
            @(negedge clk);
            chk("bp_hold_sresp", {30'd0, ocp.sresp}, {30'd0, R_DVA});
            chk("bp_hold_sdata", ocp.sdata, 32'hCAFEF00D);
            chk("bp_hold_scmdaccept", {31'd0, ocp.scmdaccept}, 32'd0);
        end
        @(posedge clk); #1;
        reg_ack = 1'b0;
        ocp.mrespaccept = 1'b1;
        @(negedge clk);
        chk("bp_accept_cycle_sresp", {30'd0, ocp.sresp}, {30'd0, R_DVA});
        chk("bp_accept_cycle_scmdaccept", {31'd0, ocp.scmdaccept}, 32'd0);
        @(posedge clk); #1;
        ocp.mrespaccept = 1'b0;
        @(negedge clk);
        chk("bp_next_scmdaccept", {31'd0, ocp.scmdaccept}, 32'd1);
        chk("bp_next_sresp", {30'd0, ocp.sresp}, 32'd0);
        sb.push_back('{R_DVA, 32'hCAFEF00D});
        complete(v);

        // Soft reset pulse during ACCESS abandons the transaction
        v = '{3'd2, 15'h0030, 4'hF, 32'h0, 6'h00, 99, 32'h0, 1'b0, 0, 0, 13'h00C, 4'hF, 1'b0, R_ERR, 32'h0};
        issue(v);
        @(posedge clk); #1;
        ocp.mcmd = 3'd0;
        @(negedge clk);
        chk("mrst_req_before", {31'd0, reg_req}, 32'd1);
        @(posedge clk); #1;
        ocp.mreset_n = 1'b0;
        @(negedge clk);
        chk("mrst_scmdaccept", {31'd0, ocp.scmdaccept}, 32'd0);
        @(posedge clk); #1;
        ocp.mreset_n = 1'b1;
        @(negedge clk);
        chk("mrst_reg_req_after", {31'd0, reg_req}, 32'd0);
        chk("mrst_reg_addr_after", {19'd0, reg_addr}, 32'd0);
        chk("mrst_sresp_after", {30'd0, ocp.sresp}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mrst_no_resp", {30'd0, ocp.sresp}, 32'd0);
            chk("mrst_no_req", {31'd0, reg_req}, 32'd0);
        end
        sb.delete();
        @(posedge clk); #1;
        run_vec(vecs[6]);

        // Hard reset during RESP drops the response
        ocp.mrespaccept = 1'b0;
        issue(vecs[2]);
        @(posedge clk); #1;
        ocp.mcmd = 3'd0;
        @(negedge clk);
        chk("rstresp_sresp_before", {30'd0, ocp.sresp}, {30'd0, R_ERR});
        @(posedge clk); #1;
        reset = 1'b1;
        ocp.mrespaccept = 1'b1;
        @(negedge clk);
        chk("rstresp_sresp_during", {30'd0, ocp.sresp}, {30'd0, R_ERR});
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstresp_sresp_after", {30'd0, ocp.sresp}, 32'd0);
        chk("rstresp_sdata_after", ocp.sdata, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
